// File: rtl/alu_issue_pkg.sv
// Shared encodings for the R-type ALU issue front end: funct codes, opcode and FSM states.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] AND_F    = 6'd36;
  localparam logic [5:0] OR_F     = 6'd37;
  localparam logic [5:0] ADD_F    = 6'd32;
  localparam logic [5:0] SUB_F    = 6'd34;
  localparam logic [5:0] SLT_F    = 6'd42;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    FAULT = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [31:0] word);
    logic [5:0] funct;
    funct = word[5:0];
    return (word[31:26] == OP_RTYPE) &&
           ((funct == AND_F) || (funct == OR_F) || (funct == ADD_F) ||
            (funct == SUB_F) || (funct == SLT_F));
  endfunction

endpackage

// File: rtl/alu_issue_unit_regfile.sv
// 32x32 register file: two operand read ports, a debug read port, writeback and preload write ports.
// Reads are combinational (read-before-write); writeback wins over preload on the same address.
module alu_regfile
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data
);

  logic [31:0] regs [32];
  logic        cfg_hit;

  assign cfg_hit = cfg_we && (cfg_addr != 5'd0) && !(wb_we && (wb_addr == cfg_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (cfg_hit) regs[cfg_addr] <= cfg_data;
      if (wb_we && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
    end
  end

  assign rs_data  = (rs_addr  == 5'd0) ? 32'd0 : regs[rs_addr];
  assign rt_data  = (rt_addr  == 5'd0) ? 32'd0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the external R-type ALU: decodes, reads operands, captures result, writes back.
// Three cycles per legal instruction (accept, EXEC, WB); illegal words take two (accept, FAULT).
module alu_issue_unit
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_dataOut,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        done,
  output logic [4:0]  done_rd,
  output logic [31:0] done_data,
  output logic        illegal
);

  state_t      state, state_next;
  logic        accept, legal;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        unused_shamt;

  assign unused_shamt = ^instr[10:6];
  assign legal  = is_legal(instr);
  assign accept = (state == IDLE) && instr_valid;

  alu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (instr[25:21]),
    .rt_addr  (instr[20:16]),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_we    (state == WB),
    .wb_addr  (rd_q),
    .wb_data  (result_q),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_signal <= '0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      state <= state_next;
      // Operands are only sampled on a legal accept; a rejected word leaves the ALU inputs alone.
      if (accept && legal) begin
        alu_dataA  <= rs_data;
        alu_dataB  <= rt_data;
        alu_signal <= instr[5:0];
        rd_q       <= instr[15:11];
      end
      if (state == EXEC) result_q <= alu_dataOut;
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = legal ? EXEC : FAULT;
      end
      EXEC: state_next = WB;
      WB: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      FAULT: begin
        illegal    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done_rd   = rd_q;
  assign done_data = result_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural R-type ALU closing the loop.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_dataA, alu_dataB, alu_dataOut;
  logic [5:0]  alu_signal;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        done;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_dataA   (alu_dataA),
    .alu_dataB   (alu_dataB),
    .alu_signal  (alu_signal),
    .alu_dataOut (alu_dataOut),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .done        (done),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .illegal     (illegal)
  );

  always_comb begin
    alu_dataOut = 32'd0;
    case (alu_signal)
      6'd36: alu_dataOut = alu_dataA & alu_dataB;
      6'd37: alu_dataOut = alu_dataA | alu_dataB;
      6'd32: alu_dataOut = alu_dataA + alu_dataB;
      6'd34: alu_dataOut = alu_dataA - alu_dataB;
      6'd42: alu_dataOut = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
      default: alu_dataOut = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts and ends at a negedge with the unit in IDLE; optionally collides a preload with the WB write.
  task automatic issue(input string tag, input logic [31:0] word, input logic [5:0] sig,
                       input logic [31:0] exp, input logic wb_cfg);
    logic [4:0] rd;
    rd = word[15:11];
    check({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr = word;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
    check({tag, " signal"}, {26'd0, alu_signal}, {26'd0, sig});
    check({tag, " exec_done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " done_rd"}, {27'd0, done_rd}, {27'd0, rd});
    check({tag, " done_data"}, done_data, exp);
    if (wb_cfg) begin
      cfg_we = 1'b1; cfg_addr = rd; cfg_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    check({tag, " ready_back"}, {31'd0, instr_ready}, 32'd1);
    peek({tag, " dbg_rd"}, rd, (rd == 5'd0) ? 32'd0 : exp);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", {31'd0, instr_ready}, 32'd1);
    check("rst dataA", alu_dataA, 32'd0);
    check("rst dataB", alu_dataB, 32'd0);
    check("rst signal", {26'd0, alu_signal}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst done_rd", {27'd0, done_rd}, 32'd0);
    check("rst done_data", done_data, 32'd0);
    reset = 1'b0;

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    preload(5'd0, 32'h1234_5678);
    peek("r0 ignores cfg", 5'd0, 32'd0);
    issue("add", 32'h0022_1820, 6'd32, 32'd8, 1'b0);
    check("add dataA", alu_dataA, 32'd5);
    check("add dataB", alu_dataB, 32'd3);
    // Dependent instruction right after writeback: r4 = r3 + r1.
    issue("dep add", 32'h0061_2020, 6'd32, 32'd13, 1'b0);

    preload(5'd1, 32'd3);
    preload(5'd2, 32'd5);
    issue("sub", 32'h0022_2022, 6'd34, 32'hFFFF_FFFE, 1'b0);
    issue("slt", 32'h0022_282A, 6'd42, 32'd1, 1'b0);
    issue("slt swap", 32'h0041_282A, 6'd42, 32'd0, 1'b0);
    issue("add r0", 32'h0022_0020, 6'd32, 32'd8, 1'b0);

    // Illegal words: one non-zero opcode, one unknown funct; neither may disturb state.
    instr_valid = 1'b1; instr = 32'h8C22_0000;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill op pulse", {31'd0, illegal}, 32'd1);
    check("ill op done", {31'd0, done}, 32'd0);
    check("ill op ready", {31'd0, instr_ready}, 32'd0);
    check("ill op signal", {26'd0, alu_signal}, 32'd32);
    @(negedge clk);
    check("ill op back", {31'd0, instr_ready}, 32'd1);
    check("ill op clear", {31'd0, illegal}, 32'd0);
    instr_valid = 1'b1; instr = 32'h0022_4018;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill fn pulse", {31'd0, illegal}, 32'd1);
    check("ill fn done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("ill fn back", {31'd0, instr_ready}, 32'd1);
    peek("ill r8", 5'd8, 32'd0);
    peek("ill r1", 5'd1, 32'd3);
    peek("ill r5", 5'd5, 32'd0);

    preload(5'd1, 32'hF0F0_F0F0);
    preload(5'd2, 32'h0FF0_0FF0);
    issue("and", 32'h0022_3024, 6'd36, 32'h00F0_00F0, 1'b0);
    issue("or", 32'h0022_3825, 6'd37, 32'hFFF0_FFF0, 1'b0);
    issue("wb vs cfg", 32'h0022_1820, 6'd32, 32'h00E1_00E0, 1'b1);

    // Reset while in EXEC: no writeback and the register file is wiped.
    instr_valid = 1'b1; instr = 32'h0022_4020;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst exec done", {31'd0, done}, 32'd0);
    check("rst exec ready", {31'd0, instr_ready}, 32'd1);
    peek("rst exec r1", 5'd1, 32'd0);
    peek("rst exec r3", 5'd3, 32'd0);
    peek("rst exec r8", 5'd8, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post rst done", {31'd0, done}, 32'd0);
    peek("post rst r8", 5'd8, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
